// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives the shared datapath.
// Latency: 3 cycles (jal/jr/beq), 4 (R-type/ori/lui/sw), 5 (lw), plus extra MEM wait cycles.
// Backpressure: holds MEM until dmem_ready; MEM_TIMEOUT cycles without it sets sticky bus_err and halts.
//
// Ports:
//   clk, reset            rising-edge clock; synchronous active-high reset
//   opcode, func          IR[31:26] / IR[5:0], stable from DECODE until the instruction ends
//   zero                  ALU zero flag (used by beq in EXEC)
//   dmem_ready            data-memory completion, sampled only in MEM
//   PCWr, IRWr            PC / IR write enables
//   RegDst                00 rt, 01 rd, 10 $31
//   ALUSrc, ExtOp         B operand select (0 reg, 1 imm); imm extension (0 zero, 1 sign)
//   ALUCtrl               000 add, 001 sub, 010 or, 011 lui
//   MemRead, MemWrite     data-memory requests, held for every MEM cycle
//   RegWrite, DatatoReg   GPR write enable; write-data select 00 ALU, 01 DM, 10 PC+4
//   PC_sel                00 PC+4, 01 branch, 10 jump target, 11 rs
//   state                 current state (debug)
//   instr_done            one-cycle pulse on the last cycle of each instruction
//   bus_err               sticky MEM-timeout flag
//   illegal               (only with ILLEGAL_TRAP_EN) sticky undecoded-instruction flag
//
// Build option ILLEGAL_TRAP_EN: undecoded instructions trap to HALT and raise illegal.
// Without it, undecoded instructions retire as a NOP at the end of DECODE.

module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       dmem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] DatatoReg,
    output logic [1:0] PC_sel,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       bus_err
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Last counter value at which MEM may still complete.
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           stateQ;
    state_t           stateD;
    logic [CNT_W-1:0] memCnt;
    logic             memTimeout;

    // Instruction decode from the latched IR fields.
    logic isRtype, isAddu, isSubu, isJr, isOri, isLui, isLw, isSw, isBeq, isJal, isLegal;

    assign isRtype = (opcode == OP_RTYPE);
    assign isAddu  = isRtype && (func == FN_ADDU);
    assign isSubu  = isRtype && (func == FN_SUBU);
    assign isJr    = isRtype && (func == FN_JR);
    assign isOri   = (opcode == OP_ORI);
    assign isLui   = (opcode == OP_LUI);
    assign isLw    = (opcode == OP_LW);
    assign isSw    = (opcode == OP_SW);
    assign isBeq   = (opcode == OP_BEQ);
    assign isJal   = (opcode == OP_JAL);
    assign isLegal = isAddu | isSubu | isJr | isOri | isLui | isLw | isSw | isBeq | isJal;

    // Timeout fires on the last allowed MEM cycle only when memory has still not answered;
    // a handshake on that same cycle completes normally.
    assign memTimeout = (stateQ == S_MEM) && !dmem_ready && (memCnt == MEM_LAST);

    assign state = stateQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= S_FETCH;
            memCnt  <= '0;
            bus_err <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            // Counter only runs while staying in MEM, so every MEM entry starts from zero.
            if ((stateQ == S_MEM) && (stateD == S_MEM)) begin
                memCnt <= memCnt + CNT_W'(1);
            end else begin
                memCnt <= '0;
            end
            if (memTimeout) begin
                bus_err <= 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            if ((stateQ == S_DECODE) && !isLegal) begin
                illegal <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        stateD     = stateQ;
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegDst     = 2'b00;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        ALUCtrl    = 3'b000;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        DatatoReg  = 2'b00;
        PC_sel     = 2'b00;
        instr_done = 1'b0;

        case (stateQ)
            S_FETCH: begin
                IRWr   = 1'b1;
                PCWr   = 1'b1;
                stateD = S_DECODE;
            end

            S_DECODE: begin
                if (!isLegal) begin
`ifdef ILLEGAL_TRAP_EN
                    stateD = S_HALT;
`else
                    instr_done = 1'b1;
                    stateD     = S_FETCH;
`endif
                end else if (isJal) begin
                    stateD = S_WB;
                end else begin
                    stateD = S_EXEC;
                end
            end

            S_EXEC: begin
                stateD = S_WB;
                if (isAddu) begin
                    ALUCtrl = 3'b000;
                end else if (isSubu) begin
                    ALUCtrl = 3'b001;
                end else if (isOri) begin
                    ALUSrc  = 1'b1;
                    ALUCtrl = 3'b010;
                end else if (isLui) begin
                    ALUSrc  = 1'b1;
                    ALUCtrl = 3'b011;
                end else if (isLw || isSw) begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                    stateD = S_MEM;
                end else if (isBeq) begin
                    ALUCtrl    = 3'b001;
                    PCWr       = zero;
                    PC_sel     = 2'b01;
                    instr_done = 1'b1;
                    stateD     = S_FETCH;
                end else if (isJr) begin
                    PCWr       = 1'b1;
                    PC_sel     = 2'b11;
                    instr_done = 1'b1;
                    stateD     = S_FETCH;
                end else begin
                    stateD = S_FETCH;
                end
            end

            S_MEM: begin
                MemRead  = isLw;
                MemWrite = isSw;
                if (dmem_ready) begin
                    if (isLw) begin
                        stateD = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        stateD     = S_FETCH;
                    end
                end else if (memTimeout) begin
                    stateD = S_HALT;
                end
            end

            S_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                stateD     = S_FETCH;
                if (isJal) begin
                    RegDst    = 2'b10;
                    DatatoReg = 2'b10;
                    PCWr      = 1'b1;
                    PC_sel    = 2'b10;
                end else if (isLw) begin
                    DatatoReg = 2'b01;
                end else if (isRtype) begin
                    RegDst = 2'b01;
                end
            end

            S_HALT: begin
                stateD = S_HALT;
            end

            default: begin
                stateD = S_FETCH;
            end
        endcase

        // Reset suppresses every side-effecting strobe for the cycle it is high.
        if (reset) begin
            PCWr       = 1'b0;
            IRWr       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, func;
    logic       zero, dmem_ready;
    logic       PCWr, IRWr, ALUSrc, ExtOp, MemRead, MemWrite, RegWrite, instr_done, bus_err;
    logic [1:0] RegDst, DatatoReg, PC_sel;
    logic [2:0] ALUCtrl, state;
    logic       illegalOut;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
        .dmem_ready(dmem_ready), .PCWr(PCWr), .IRWr(IRWr), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .DatatoReg(DatatoReg),
        .PC_sel(PC_sel), .state(state), .instr_done(instr_done), .bus_err(bus_err)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegalOut)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegalOut = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       pcWr, irWr;
        logic [1:0] regDst;
        logic       aluSrc, extOp;
        logic [2:0] aluCtrl;
        logic       memRead, memWrite, regWrite;
        logic [1:0] datToReg, pcSel;
        logic       done, busErr, ill;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic dm;
        logic z;
    } step_t;

    obs_t  expQ[$];
    step_t seq[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;

    // Architectural model state.
    logic  mBusErr = 1'b0;
    logic  mIll    = 1'b0;
    logic  mHalt   = 1'b0;
    logic [5:0] curOp = 6'd0, curFn = 6'd0;

    // Monitor: compares every observed cycle against the next queued expectation.
    always @(negedge clk) begin
        obs_t act, e;
        cyc++;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            act = {state, PCWr, IRWr, RegDst, ALUSrc, ExtOp, ALUCtrl, MemRead, MemWrite,
                   RegWrite, DatatoReg, PC_sel, instr_done, bus_err, illegalOut};
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL cycle%0d op=%b fn=%b: got st=%0d ctl=%b, want st=%0d ctl=%b",
                         cyc, curOp, curFn, act.st, act[17:0], e.st, e[17:0]);
            end
        end
    end

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o        = '0;
        o.st     = st;
        o.busErr = mBusErr;
        o.ill    = mIll;
        return o;
    endfunction

    function automatic obs_t noStrobes(input obs_t i);
        obs_t o;
        o          = i;
        o.pcWr     = 1'b0;
        o.irWr     = 1'b0;
        o.memRead  = 1'b0;
        o.memWrite = 1'b0;
        o.regWrite = 1'b0;
        o.done     = 1'b0;
        return o;
    endfunction

    task automatic add(input obs_t o, input logic dm, input logic z);
        step_t s;
        s.exp = o;
        s.dm  = dm;
        s.z   = z;
        seq.push_back(s);
    endtask

    // Reference model: expected phase list for one instruction.
    // memWait = MEM cycle on which dmem_ready rises (1 = entry cycle); 0 = never (timeout).
    task automatic buildSeq(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int memWait);
        obs_t o;
        bit rt, addu, subu, jr, ori, lui, lw, sw, beq, jal, legal;
        int n;
        rt    = (op == 6'h00);
        addu  = rt && fn == 6'h21;
        subu  = rt && fn == 6'h23;
        jr    = rt && fn == 6'h08;
        ori   = op == 6'h0d;
        lui   = op == 6'h0f;
        lw    = op == 6'h23;
        sw    = op == 6'h2b;
        beq   = op == 6'h04;
        jal   = op == 6'h03;
        legal = addu | subu | jr | ori | lui | lw | sw | beq | jal;
        seq.delete();

        o = blank(3'd0); o.irWr = 1; o.pcWr = 1;
        add(o, 1'($urandom), 1'($urandom));

        o = blank(3'd1);
        if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
            add(o, 1'($urandom), 1'($urandom));
            mIll  = 1'b1;
            mHalt = 1'b1;
`else
            o.done = 1;
            add(o, 1'($urandom), 1'($urandom));
`endif
            return;
        end
        add(o, 1'($urandom), 1'($urandom));

        if (jal) begin
            o = blank(3'd4); o.regWrite = 1; o.done = 1; o.regDst = 2; o.datToReg = 2;
            o.pcWr = 1; o.pcSel = 2;
            add(o, 1'($urandom), 1'($urandom));
            return;
        end

        o = blank(3'd2);
        if (subu) o.aluCtrl = 1;
        if (ori) begin o.aluSrc = 1; o.aluCtrl = 2; end
        if (lui) begin o.aluSrc = 1; o.aluCtrl = 3; end
        if (lw || sw) begin o.aluSrc = 1; o.extOp = 1; end
        if (beq) begin o.aluCtrl = 1; o.pcWr = z; o.pcSel = 1; o.done = 1; end
        if (jr) begin o.pcWr = 1; o.pcSel = 3; o.done = 1; end
        add(o, 1'($urandom), z);
        if (beq || jr) return;

        if (lw || sw) begin
            n = (memWait == 0) ? 15 : memWait;
            for (int i = 1; i <= n; i++) begin
                o = blank(3'd3); o.memRead = lw; o.memWrite = sw;
                if (memWait != 0 && i == n && sw) o.done = 1;
                add(o, (memWait != 0 && i == n), 1'($urandom));
            end
            if (memWait == 0) begin
                mBusErr = 1'b1;
                mHalt   = 1'b1;
                return;
            end
            if (sw) return;
        end

        o = blank(3'd4); o.regWrite = 1; o.done = 1;
        if (rt) o.regDst = 1;
        if (lw) o.datToReg = 1;
        add(o, 1'($urandom), 1'($urandom));
    endtask

    // Drives the first `upto` steps; caller is aligned 1 time unit after a rising edge.
    task automatic drive(input int upto);
        for (int i = 0; i < upto; i++) begin
            opcode     = curOp;
            func       = curFn;
            dmem_ready = seq[i].dm;
            zero       = seq[i].z;
            expQ.push_back(seq[i].exp);
            @(posedge clk); #1;
        end
    endtask

    task automatic haltCycles(input int n);
        for (int i = 0; i < n; i++) begin
            opcode     = 6'($urandom);
            func       = 6'($urandom);
            dmem_ready = 1'($urandom);
            zero       = 1'($urandom);
            expQ.push_back(blank(3'd5));
            @(posedge clk); #1;
        end
    endtask

    // One-cycle reset pulse; e is what the current cycle would show without reset.
    task automatic pulseReset(input obs_t e);
        reset = 1'b1;
        expQ.push_back(noStrobes(e));
        @(posedge clk); #1;
        reset   = 1'b0;
        mBusErr = 1'b0;
        mIll    = 1'b0;
        mHalt   = 1'b0;
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int memWait);
        curOp = op;
        curFn = fn;
        buildSeq(op, fn, z, memWait);
        drive(seq.size());
        if (mHalt) begin
            haltCycles(3);
            pulseReset(blank(3'd5));
        end
    endtask

    // Start an instruction and reset it after k cycles.
    task automatic abortInstr(input logic [5:0] op, input logic [5:0] fn, input int memWait);
        int k;
        curOp = op;
        curFn = fn;
        buildSeq(op, fn, 1'($urandom), memWait);
        k = $urandom_range(0, seq.size() - 1);
        drive(k);
        pulseReset(seq[k].exp);
    endtask

    logic [5:0] opTab [12];
    logic [5:0] fnTab [12];

    initial begin
        reset = 1'b1; opcode = '0; func = '0; zero = 0; dmem_ready = 0;
        opTab = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03, 6'h3f,
                  6'h00, 6'h23};
        fnTab = '{6'h21, 6'h23, 6'h08, 6'h15, 6'h2a, 6'h00, 6'h3f, 6'h01, 6'h11, 6'h3f,
                  6'h00, 6'h09};
        @(posedge clk); #1;
        // Reset held: state FETCH, strobes suppressed, flags clear.
        expQ.push_back(blank(3'd0));
        @(posedge clk); #1;
        reset = 1'b0;

        runInstr(6'h00, 6'h21, 1'b0, 0);  // addu
        runInstr(6'h00, 6'h23, 1'b1, 0);  // subu
        runInstr(6'h23, 6'h00, 1'b0, 3);  // lw, ready 3 cycles into MEM
        runInstr(6'h04, 6'h00, 1'b1, 0);  // beq taken
        runInstr(6'h04, 6'h00, 1'b0, 0);  // beq not taken
        runInstr(6'h03, 6'h00, 1'b0, 0);  // jal
        runInstr(6'h00, 6'h08, 1'b0, 0);  // jr
        runInstr(6'h0d, 6'h00, 1'b0, 0);  // ori
        runInstr(6'h0f, 6'h00, 1'b0, 0);  // lui
        runInstr(6'h2b, 6'h00, 1'b0, 1);  // sw, ready on entry
        runInstr(6'h23, 6'h00, 1'b0, 1);  // lw, ready on entry
        runInstr(6'h23, 6'h00, 1'b0, 15); // lw, ready on last allowed cycle
        runInstr(6'h2b, 6'h00, 1'b0, 0);  // sw timeout -> bus_err, HALT, reset
        runInstr(6'h3f, 6'h00, 1'b0, 0);  // undecoded opcode
        runInstr(6'h00, 6'h00, 1'b0, 0);  // undecoded R-type func
        abortInstr(6'h23, 6'h00, 6);
        runInstr(6'h2b, 6'h00, 1'b0, 0);  // counter must restart after abort

        for (int t = 0; t < 120; t++) begin
            int idx, w;
            idx = $urandom_range(0, 11);
            w   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 7) == 0) begin
                abortInstr(opTab[idx], fnTab[idx], w);
            end else begin
                runInstr(opTab[idx], fnTab[idx], 1'($urandom), w);
            end
        end

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
